// File: rtl/reg_alu_seq.sv
// Register file + ALU datapath stepped through read / execute / write-back phases
// by a debounced front-panel button, with a registered display mux.
module reg_alu_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEB_CYC = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              auto_mode,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [3:0]        ALU_OP,
    input  logic              Reg_Write,
    input  logic              imm_sel,
    input  logic [7:0]        imm,
    input  logic [1:0]        disp_sel,
    output logic [WIDTH-1:0]  disp_data,
    output logic [3:0]        FR,
    output logic [1:0]        phase,
    output logic              done
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RR   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t            state;
    logic              sync1, sync2, stable, step_pulse;
    logic [CNT_W-1:0]  deb_cnt;
    logic [WIDTH-1:0]  a, b, f;
    logic [WIDTH-1:0]  regs [NREG];

    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  diff;
    logic [SH_W-1:0]   sh;
    logic              slt;
    logic [WIDTH-1:0]  alu_f;
    logic              alu_cf, alu_of;
    logic              adv;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a - b;
    assign sh   = b[SH_W-1:0];
    assign slt  = $signed(a) < $signed(b);
    assign adv  = auto_mode | step_pulse;

    // ALU: result plus carry/borrow and signed overflow for ADD/SUB only
    always_comb begin
        alu_f  = '0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        case (ALU_OP)
            4'd0: alu_f = a & b;
            4'd1: alu_f = a | b;
            4'd2: alu_f = a ^ b;
            4'd3: alu_f = ~(a | b);
            4'd4: begin
                alu_f  = sum[WIDTH-1:0];
                alu_cf = sum[WIDTH];
                alu_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd5: begin
                alu_f  = diff;
                alu_cf = a < b;
                alu_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd6: alu_f = {{(WIDTH-1){1'b0}}, slt};
            4'd7: alu_f = a << sh;
            4'd8: alu_f = a >> sh;
            4'd9: alu_f = WIDTH'($signed(a) >>> sh);
            default: alu_f = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable     <= 1'b0;
            deb_cnt    <= '0;
            step_pulse <= 1'b0;
            state      <= ST_IDLE;
            a          <= '0;
            b          <= '0;
            f          <= '0;
            FR         <= '0;
            done       <= 1'b0;
            disp_data  <= '0;
            regs       <= '{default: '0};
        end else begin
            sync1      <= step;
            sync2      <= sync1;
            step_pulse <= 1'b0;
            done       <= 1'b0;

            // accept a new level only after DEB_CYC consecutive differing samples
            if (sync2 != stable) begin
                if (deb_cnt == CNT_W'(DEB_CYC - 1)) begin
                    stable     <= sync2;
                    deb_cnt    <= '0;
                    step_pulse <= sync2;
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end

            case (state)
                ST_IDLE: if (step_pulse) begin
                    a     <= regs[R_Addr_A];
                    b     <= regs[R_Addr_B];
                    state <= ST_RR;
                end
                ST_RR: if (adv) begin
                    f     <= alu_f;
                    FR    <= {alu_f == '0, alu_cf, alu_of, alu_f[WIDTH-1]};
                    state <= ST_EX;
                end
                ST_EX: if (adv) begin
                    // register 0 is never written, so it reads as zero
                    if (Reg_Write && (W_Addr != '0))
                        regs[W_Addr] <= imm_sel ? WIDTH'(imm) : f;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            case (disp_sel)
                2'd0:    disp_data <= a;
                2'd1:    disp_data <= b;
                2'd2:    disp_data <= f;
                default: disp_data <= regs[R_Addr_A];
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_reg_alu_seq.sv
// Bench for reg_alu_seq: 32- and 16-bit instances share stimulus; expected F/FR per
// sequence are queued on stimulus and compared when done pulses.
module tb_reg_alu_seq;

    localparam int unsigned DEB = 4;

    logic        clk = 1'b0;
    logic        rst, step, auto_mode, Reg_Write, imm_sel;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic [3:0]  ALU_OP;
    logic [7:0]  imm;
    logic [1:0]  disp_sel;

    logic [31:0] disp32;
    logic [15:0] disp16;
    logic [3:0]  fr32, fr16;
    logic [1:0]  phase32, phase16;
    logic        done32, done16;

    always #5 clk = ~clk;

    reg_alu_seq #(.WIDTH(32), .ADDR_W(5), .DEB_CYC(DEB)) dut32 (
        .clk(clk), .rst(rst), .step(step), .auto_mode(auto_mode),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .ALU_OP(ALU_OP),
        .Reg_Write(Reg_Write), .imm_sel(imm_sel), .imm(imm), .disp_sel(disp_sel),
        .disp_data(disp32), .FR(fr32), .phase(phase32), .done(done32));

    reg_alu_seq #(.WIDTH(16), .ADDR_W(5), .DEB_CYC(DEB)) dut16 (
        .clk(clk), .rst(rst), .step(step), .auto_mode(auto_mode),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .ALU_OP(ALU_OP),
        .Reg_Write(Reg_Write), .imm_sel(imm_sel), .imm(imm), .disp_sel(disp_sel),
        .disp_data(disp16), .FR(fr16), .phase(phase16), .done(done16));

    typedef struct {
        logic [4:0]  ra, rb, wa;
        logic [3:0]  op;
        logic        we, isel;
        logic [7:0]  imm;
        logic        man, bnc;
        logic [31:0] f32;
        logic [3:0]  fr32;
        logic [15:0] f16;
        logic [3:0]  fr16;
    } vec_t;

    typedef struct packed {
        logic [31:0] f32;
        logic [3:0]  fr32;
        logic [15:0] f16;
        logic [3:0]  fr16;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wa,
                                input logic [3:0] op, input logic we, input logic isel,
                                input logic [7:0] im, input logic man, input logic bnc,
                                input logic [31:0] f32, input logic [3:0] fr32,
                                input logic [15:0] f16, input logic [3:0] fr16);
        vec_t v;
        v.ra = ra; v.rb = rb; v.wa = wa; v.op = op; v.we = we; v.isel = isel; v.imm = im;
        v.man = man; v.bnc = bnc; v.f32 = f32; v.fr32 = fr32; v.f16 = f16; v.fr16 = fr16;
        return v;
    endfunction

    // seeding: A=B=r0, ADD -> F=0, ZF only; WB writes the immediate
    function automatic vec_t seed(input logic [4:0] wa, input logic [7:0] im);
        return mk(5'd0, 5'd0, wa, 4'd4, 1'b1, 1'b1, im, 1'b0, 1'b0,
                  32'h0, 4'b1000, 16'h0, 4'b1000);
    endfunction

    // scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done32) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done32), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done16", 32'(done16), 32'd1);
                chk("fr32", 32'(fr32), 32'(e.fr32));
                chk("fr16", 32'(fr16), 32'(e.fr16));
                if (disp_sel == 2'd2) begin
                    chk("f32", disp32, e.f32);
                    chk("f16", 32'(disp16), 32'(e.f16));
                end
            end
        end
    end

    task automatic wait_phase(input logic [1:0] p, input string nm);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (phase32 == p) break;
        end
        chk(nm, 32'(phase32), 32'(p));
    endtask

    task automatic release_step();
        step = 1'b0;
        repeat (3 * DEB) @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        R_Addr_A = v.ra; R_Addr_B = v.rb; W_Addr = v.wa; ALU_OP = v.op;
        Reg_Write = v.we; imm_sel = v.isel; imm = v.imm;
        disp_sel = 2'd2; auto_mode = ~v.man;
    endtask

    task automatic run_auto(input vec_t v);
        apply(v);
        sb.push_back({v.f32, v.fr32, v.f16, v.fr16});
        step = 1'b1;
        wait_phase(2'd1, "auto_rr");            // cycle n+1
        @(negedge clk);                         // n+2: F/FR valid
        chk("auto_ex", 32'(phase32), 32'd2);
        chk("auto_fr_n2", 32'(fr32), 32'(v.fr32));
        @(negedge clk);                         // n+3: done, back in IDLE
        chk("auto_done_n3", 32'(done32), 32'd1);
        chk("auto_idle_n3", 32'(phase32), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done32), 32'd0);
        release_step();
    endtask

    task automatic run_manual(input vec_t v);
        apply(v);
        if (v.bnc) begin
            for (int g = 0; g < 5; g++) begin
                step = 1'b1; repeat (2) @(negedge clk);
                step = 1'b0; repeat (2) @(negedge clk);
            end
            repeat (6) @(negedge clk);
            chk("bounce_idle", 32'(phase32), 32'd0);
        end
        sb.push_back({v.f32, v.fr32, v.f16, v.fr16});
        step = 1'b1;
        wait_phase(2'd1, "man_rr");
        repeat (3 * DEB) @(negedge clk);
        chk("hold_no_repeat", 32'(phase32), 32'd1);
        release_step();
        chk("man_rr_stay", 32'(phase32), 32'd1);
        step = 1'b1;
        wait_phase(2'd2, "man_ex");
        chk("man_fr", 32'(fr32), 32'(v.fr32));
        release_step();
        chk("man_ex_stay", 32'(phase32), 32'd2);
        step = 1'b1;
        wait_phase(2'd0, "man_idle");
        release_step();
    endtask

    task automatic live(input logic [4:0] ra, input logic [31:0] e32, input logic [15:0] e16,
                        input string nm);
        disp_sel = 2'd3; R_Addr_A = ra;
        repeat (2) @(negedge clk);
        chk({nm, "_32"}, disp32, e32);
        chk({nm, "_16"}, 32'(disp16), 32'(e16));
    endtask

    initial begin
        logic saw_done;
        rst = 1'b1; step = 1'b0; auto_mode = 1'b0; Reg_Write = 1'b0; imm_sel = 1'b0;
        R_Addr_A = '0; R_Addr_B = '0; W_Addr = '0; ALU_OP = '0; imm = '0; disp_sel = 2'd2;

        //            ra     rb     wa     op     we    isel  imm    man   bnc   F32           FR32     F16       FR16
        vecs.push_back(mk(5'd0, 5'd0, 5'd0, 4'd4, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 32'h0,        4'b1000, 16'h0,    4'b1000));
        vecs.push_back(seed(5'd4, 8'h01));
        vecs.push_back(seed(5'd5, 8'h1F));
        vecs.push_back(seed(5'd3, 8'h7F));
        vecs.push_back(mk(5'd4, 5'd5, 5'd6, 4'd7, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 32'h80000000, 4'b0001, 16'h8000, 4'b0001));
        vecs.push_back(mk(5'd6, 5'd4, 5'd1, 4'd5, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 32'h7FFFFFFF, 4'b0010, 16'h7FFF, 4'b0010));
        vecs.push_back(seed(5'd2, 8'h01));
        vecs.push_back(mk(5'd1, 5'd2, 5'd0, 4'd4, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 32'h80000000, 4'b0011, 16'h8000, 4'b0011));
        vecs.push_back(mk(5'd0, 5'd4, 5'd0, 4'd4, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h1,        4'b0000, 16'h1,    4'b0000));
        vecs.push_back(seed(5'd1, 8'h01));
        vecs.push_back(seed(5'd2, 8'h02));
        vecs.push_back(mk(5'd1, 5'd2, 5'd0, 4'd5, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b0101, 16'hFFFF, 4'b0101));
        vecs.push_back(seed(5'd7, 8'h04));
        vecs.push_back(mk(5'd6, 5'd7, 5'd8, 4'd9, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 32'hF8000000, 4'b0001, 16'hF800, 4'b0001));
        vecs.push_back(mk(5'd6, 5'd7, 5'd0, 4'd12,1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h0,        4'b1000, 16'h0,    4'b1000));
        vecs.push_back(mk(5'd6, 5'd1, 5'd0, 4'd2, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h80000001, 4'b0001, 16'h8001, 4'b0001));
        vecs.push_back(mk(5'd6, 5'd4, 5'd0, 4'd6, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h1,        4'b0000, 16'h1,    4'b0000));
        vecs.push_back(mk(5'd6, 5'd7, 5'd0, 4'd8, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h08000000, 4'b0000, 16'h0800, 4'b0000));
        vecs.push_back(mk(5'd0, 5'd0, 5'd0, 4'd3, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b0001, 16'hFFFF, 4'b0001));
        vecs.push_back(mk(5'd6, 5'd6, 5'd0, 4'd4, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h0,        4'b1110, 16'h0,    4'b1110));
        vecs.push_back(mk(5'd4, 5'd4, 5'd0, 4'd5, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h0,        4'b1000, 16'h0,    4'b1000));
        vecs.push_back(mk(5'd8, 5'd6, 5'd0, 4'd0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h80000000, 4'b0001, 16'h8000, 4'b0001));
        vecs.push_back(mk(5'd4, 5'd6, 5'd0, 4'd6, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h0,        4'b1000, 16'h0,    4'b1000));
        vecs.push_back(mk(5'd4, 5'd5, 5'd0, 4'd5, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 32'hFFFFFFE2, 4'b0101, 16'hFFE2,  4'b0101));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_phase", 32'(phase32), 32'd0);
        chk("rst_done", 32'(done32), 32'd0);
        chk("rst_fr", 32'(fr32), 32'd0);
        chk("rst_disp32", disp32, 32'd0);
        chk("rst_disp16", 32'(disp16), 32'd0);
        chk("rst_phase16", 32'(phase16), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].man) run_manual(vecs[i]);
            else             run_auto(vecs[i]);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        live(5'd3, 32'h0000007F, 16'h007F, "live_r3");
        live(5'd8, 32'hF8000000, 16'hF800, "live_r8");
        live(5'd0, 32'h0,        16'h0,    "live_r0");

        // reset while in EX: no write, registers cleared, no done
        apply(mk(5'd3, 5'd3, 5'd3, 4'd4, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 32'h0, 4'h0, 16'h0, 4'h0));
        step = 1'b1;
        wait_phase(2'd1, "rst_seq_rr");
        release_step();
        step = 1'b1;
        wait_phase(2'd2, "rst_seq_ex");
        release_step();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        chk("rst_ex_phase", 32'(phase32), 32'd0);
        chk("rst_ex_fr", 32'(fr32), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done32 || done16) saw_done = 1'b1;
        end
        chk("rst_ex_no_done", 32'(saw_done), 32'd0);
        live(5'd3, 32'h0, 16'h0, "rst_clr_r3");
        live(5'd8, 32'h0, 16'h0, "rst_clr_r8");
        live(5'd6, 32'h0, 16'h0, "rst_clr_r6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
